// File: rtl/prf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prf_pkg
// Description : Shared constants and types for the physical register file
//               with ready scoreboard.
//               Provides the default data width, register count, port counts,
//               hardwired-zero tag, derived tag width, and the tag/data
//               typedefs.
// Revision    : 1.0 - initial release
// ============================================================================
package prf_pkg;

  localparam int XLEN      = 64;
  localparam int PRF_DEPTH = 64;
  localparam int NUM_RD    = 6;
  localparam int NUM_WR    = 3;
  localparam int NUM_ALLOC = 3;
  localparam int ZERO_TAG  = 0;
  localparam int ADDR_W    = $clog2(PRF_DEPTH);

  typedef logic [ADDR_W-1:0] prf_tag_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage : prf_pkg
`default_nettype wire

// File: rtl/prf_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module      : prf_bypass_mux
// Description : Read-side resolution for one read port. It handles the two
//               cases that bypass storage: the hardwired-zero tag, and
//               same-cycle forwarding from any write port. When several write
//               ports target the tag, the highest-index port wins.
//   rd_addr_i  - tag being read
//   wr_en_i    - write valid, one bit per write port
//   wr_addr_i  - write tags
//   wr_data_i  - write data
//   data_o     - resolved data; valid only when hit_o is set
//   ready_o    - resolved ready; valid only when hit_o is set
//   hit_o      - the read was resolved here (zero tag or forward), so the
//                caller must not use storage
// Revision    : 1.0 - initial release
// ============================================================================
module prf_bypass_mux #(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 6,
  parameter int NUM_WR   = 3,
  parameter int ZERO_TAG = 0
) (
  input  logic [ADDR_W-1:0]             rd_addr_i,
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          ready_o,
  output logic                          hit_o
);

  localparam logic [ADDR_W-1:0] c_zero_tag = ADDR_W'(ZERO_TAG);

  always_comb begin
    data_o  = '0;
    ready_o = 1'b0;
    hit_o   = 1'b0;
    // Ascending scan: a later (higher-index) match overwrites an earlier one.
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j] == rd_addr_i)) begin
        data_o  = wr_data_i[j];
        ready_o = 1'b1;
        hit_o   = 1'b1;
      end
    end
    // The zero tag outranks forwarding, even from a (discarded) write to it.
    if (rd_addr_i == c_zero_tag) begin
      data_o  = '0;
      ready_o = 1'b1;
      hit_o   = 1'b1;
    end
  end

endmodule : prf_bypass_mux
`default_nettype wire

// File: rtl/prf_scb.sv
`default_nettype none
// ============================================================================
// Module      : prf_scb
// Description : Physical register file with a per-register ready scoreboard.
//               The number of read, write and allocation ports is set by
//               parameter. Every write port forwards to every read port in the
//               same cycle. Allocation clears a tag's ready bit and writeback
//               sets it. When both hit the same tag in one cycle, allocation
//               wins.
//   clk         - clock
//   rst         - synchronous active-high reset: regs=0, all ready
//   rd_addr_i   - read tags, one per read port
//   rd_data_o   - read data (combinational)
//   rd_ready_o  - ready bit for the read tag (combinational)
//   wr_en_i     - write valid, one per write port
//   wr_addr_i   - write tags
//   wr_data_i   - write data
//   alloc_en_i  - allocation valid, one per allocation port
//   alloc_tag_i - newly renamed destination tags
// Revision    : 1.0 - initial release
// ============================================================================
module prf_scb #(
  parameter int XLEN      = prf_pkg::XLEN,
  parameter int PRF_DEPTH = prf_pkg::PRF_DEPTH,
  parameter int NUM_RD    = prf_pkg::NUM_RD,
  parameter int NUM_WR    = prf_pkg::NUM_WR,
  parameter int NUM_ALLOC = prf_pkg::NUM_ALLOC,
  parameter int ZERO_TAG  = prf_pkg::ZERO_TAG,
  parameter int ADDR_W    = $clog2(PRF_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]      rd_data_o,
  output logic [NUM_RD-1:0]                rd_ready_o,
  input  logic [NUM_WR-1:0]                wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]      wr_data_i,
  input  logic [NUM_ALLOC-1:0]             alloc_en_i,
  input  logic [NUM_ALLOC-1:0][ADDR_W-1:0] alloc_tag_i
);

  import prf_pkg::*;

  localparam logic [ADDR_W-1:0] c_zero_tag = ADDR_W'(ZERO_TAG);

  logic [XLEN-1:0]      regs_q [PRF_DEPTH];
  logic [XLEN-1:0]      regs_d [PRF_DEPTH];
  logic [PRF_DEPTH-1:0] rdy_q;
  logic [PRF_DEPTH-1:0] rdy_d;

  logic [NUM_RD-1:0][XLEN-1:0] w_fwd_data;
  logic [NUM_RD-1:0]           w_fwd_ready;
  logic [NUM_RD-1:0]           w_fwd_hit;

  // Next state. Writes are applied in ascending port order, so the highest
  // index wins on duplicate tags. Allocations are applied after all writes,
  // so a same-cycle alloc leaves the bit clear while the data still lands.
  // The zero tag is never updated, so its reset value (0, ready) holds.
  always_comb begin
    regs_d = regs_q;
    rdy_d  = rdy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j] != c_zero_tag)) begin
        regs_d[wr_addr_i[j]] = wr_data_i[j];
        rdy_d[wr_addr_i[j]]  = 1'b1;
      end
    end
    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (alloc_en_i[k] && (alloc_tag_i[k] != c_zero_tag)) begin
        rdy_d[alloc_tag_i[k]] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PRF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      rdy_q <= '1;
    end else begin
      regs_q <= regs_d;
      rdy_q  <= rdy_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
      prf_bypass_mux #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_TAG (ZERO_TAG)
      ) u_bypass (
        .rd_addr_i (rd_addr_i[i]),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .data_o    (w_fwd_data[i]),
        .ready_o   (w_fwd_ready[i]),
        .hit_o     (w_fwd_hit[i])
      );

      assign rd_data_o[i]  = w_fwd_hit[i] ? w_fwd_data[i]  : regs_q[rd_addr_i[i]];
      assign rd_ready_o[i] = w_fwd_hit[i] ? w_fwd_ready[i] : rdy_q[rd_addr_i[i]];
    end
  endgenerate

endmodule : prf_scb
`default_nettype wire

// File: doc/prf_scb.md
Name: prf_scb

Overview:
- Parametrised successor to the issue-stage physical register file.
- Arbitrary read-port and write-port counts, with full cross-port write-to-read forwarding.
- Adds a per-register ready scoreboard: dispatch clears a tag's bit on allocation, writeback sets it.
- Sits between rename/dispatch (alloc), the issue queues (ready lookup, operand read) and the CDB/writeback (write); replaces the separate busy table.

Parameters:
- XLEN, 64, data width.
- PRF_DEPTH, 64, number of physical registers (power of two, >=2).
- NUM_RD, 6, read ports (each returns data and ready).
- NUM_WR, 3, write ports.
- NUM_ALLOC, 3, allocation ports (ready-clear).
- ZERO_TAG, 0, hardwired-zero physical tag.
- ADDR_W, $clog2(PRF_DEPTH), derived tag width; do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  [NUM_RD][ADDR_W]  read tags.
- rd_data  out  [NUM_RD][XLEN]  read data, combinational.
- rd_ready  out  [NUM_RD]  ready bit for rd_addr, combinational.
- wr_en  in  [NUM_WR]  write valid.
- wr_addr  in  [NUM_WR][ADDR_W]  write tag.
- wr_data  in  [NUM_WR][XLEN]  write data.
- alloc_en  in  [NUM_ALLOC]  allocation valid.
- alloc_tag  in  [NUM_ALLOC][ADDR_W]  newly renamed destination tag.

Behaviour:
- Storage: regs[PRF_DEPTH][XLEN] and rdy[PRF_DEPTH].
- Reset (rst=1 at posedge): all regs=0; all rdy=1, matching the initial identity map with architectural values ready. Reset overrides any same-cycle wr/alloc. Outputs are combinational, so during and after reset a read returns 0/ready=1 for any tag not currently being written.
- Read, 0-cycle latency, evaluated per port in priority order:
  1. rd_addr==ZERO_TAG gives data 0, ready 1.
  2. Else the highest-index write port j with wr_en[j] && wr_addr[j]==rd_addr gives data wr_data[j], ready 1 (forwarding from every write port to every read port).
  3. Else regs[rd_addr], rdy[rd_addr].
- Write, at posedge:
  - For each j with wr_en[j] && wr_addr[j]!=ZERO_TAG: regs <= wr_data, rdy <= 1.
  - Duplicate addr across write ports in one cycle: highest index wins for both storage and forwarding. This is an illegal usage condition; the bench flags it but the result is deterministic.
- Alloc, at posedge: for each k with alloc_en[k] && alloc_tag[k]!=ZERO_TAG: rdy <= 0. Data is untouched.
- Same tag allocated and written in the same cycle: alloc wins, rdy=0, but data is still written. Same-cycle forwarding to reads is still reported ready=1, since a read sees the write.
- Writes to or allocation of ZERO_TAG are ignored; regs[ZERO_TAG] stays 0 and rdy stays 1.
- Out-of-range tags are impossible by construction because PRF_DEPTH is a power of two.
- No handshake or backpressure; all inputs are sampled every cycle.
- rdy is a multi-bit-write register array: each bit's next state is the OR-reduction of matching writes, then AND with not-matching allocs (alloc priority).

Decomposition:
- Shared package prf_pkg:
  - XLEN, PRF_DEPTH, ZERO_TAG, derived ADDR_W;
  - typedef prf_tag_t = logic[ADDR_W-1:0];
  - typedef xlen_t = logic[XLEN-1:0];
  - port-count constants.
- One sub-module prf_bypass_mux: per-read-port priority match over NUM_WR write ports, producing data/ready/hit. Instantiated NUM_RD times.
- Storage and scoreboard stay in prf_scb.

Test Plan:
- Reset, then read tags 0..63 -> data 0, ready 1 on all ports.
- alloc tag 5; next cycle rd_addr=5 -> ready 0. Then wr port2 tag5 data 0xDEAD -> same cycle rd_data=0xDEAD, ready 1. Next cycle (no write) -> 0xDEAD, ready 1.
- Same cycle: wr port0 and port2 both to tag 9 with data 0x11/0x22 -> forwarded 0x22; stored 0x22 next cycle.
- Same cycle: alloc tag 7 and wr tag7=0x55 -> read that cycle 0x55/ready 1; next cycle 0x55/ready 0.
- wr and alloc on ZERO_TAG with data 0xFF -> rd tag0 always 0, ready 1.
- Reset asserted while wr tag 3=0x77 and alloc tag 4 -> next cycle tag3=0/ready 1, tag4 ready 1.
